// File: rtl/mem_access.sv
// mem_access: load/store bus master sitting between CPU control and an
// Avalon-MM style memory port. IDLE -> ACCESS -> DONE, every output
// comes straight from a register.
// Optional feature macro: MEM_ACCESS_ALIGN_CHECK_EN (misaligned half/word
// requests are rejected with fault_o instead of issuing a bus cycle).
module mem_access (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        write_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] address_i,
  input  logic [1:0]  byte_offset_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] avm_address_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  output logic [31:0] avm_writedata_o,
  output logic [3:0]  avm_byteenable_o,
  input  logic        avm_waitrequest_i,
  input  logic [31:0] avm_readdata_i,
  output logic [31:0] readdata_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  be_reg, be_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        read_reg, read_next;
  logic        write_reg, write_next;
  logic        done_reg, done_next;
  logic        busy_reg, busy_next;
  logic        misaligned;

  // Byte lanes touched by an access; lane 0 (offset 0) is bits [31:24].
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      2'b00:   mask = 4'b1000 >> off;
      2'b01:   mask = off[1] ? 4'b0011 : 4'b1100;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic fault_reg, fault_next;
  assign misaligned = ((size_i == 2'b01) && byte_offset_i[0]) ||
                      ((size_i == 2'b10) && (byte_offset_i != 2'b00));
  assign fault_o    = fault_reg;
`else
  assign misaligned = 1'b0;
  assign fault_o    = 1'b0;
`endif

  // State and all output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      rdata_reg <= '0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      fault_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      be_reg    <= be_next;
      rdata_reg <= rdata_next;
      read_reg  <= read_next;
      write_reg <= write_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      fault_reg <= fault_next;
`endif
    end
  end

  // Next-state: start only matters in IDLE; ACCESS waits out waitrequest.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i) state_next = misaligned ? DONE : ACCESS;
      ACCESS:  if (!avm_waitrequest_i) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output next-values: request fields are latched once and held until done.
  always_comb begin
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    be_next    = be_reg;
    rdata_next = rdata_reg;
    read_next  = 1'b0;
    write_next = 1'b0;
    done_next  = 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    fault_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (start_i && !misaligned) begin
          // Masking keeps the whole address port in use while dropping [1:0].
          addr_next  = address_i & 32'hFFFF_FFFC;
          wdata_next = store_data_i;
          be_next    = lane_mask(size_i, byte_offset_i);
          read_next  = ~write_i;
          write_next = write_i;
        end
        if (start_i && misaligned) begin
          done_next = 1'b1;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
          fault_next = 1'b1;
`endif
        end
      end
      ACCESS: begin
        read_next  = read_reg;
        write_next = write_reg;
        if (!avm_waitrequest_i) begin
          read_next  = 1'b0;
          write_next = 1'b0;
          done_next  = 1'b1;
          if (read_reg) rdata_next = avm_readdata_i;
        end
      end
      default: ;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign avm_address_o    = addr_reg;
  assign avm_read_o       = read_reg;
  assign avm_write_o      = write_reg;
  assign avm_writedata_o  = wdata_reg;
  assign avm_byteenable_o = be_reg;
  assign readdata_o       = rdata_reg;
  assign done_o           = done_reg;
  assign busy_o           = busy_reg;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized loads/stores
// against a lane-based reference model of the access rules.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        write_i;
  logic [1:0]  size_i;
  logic [31:0] address_i;
  logic [1:0]  byte_offset_i;
  logic [31:0] store_data_i;
  logic [31:0] avm_address_o;
  logic        avm_read_o;
  logic        avm_write_o;
  logic [31:0] avm_writedata_o;
  logic [3:0]  avm_byteenable_o;
  logic        avm_waitrequest_i;
  logic [31:0] avm_readdata_i;
  logic [31:0] readdata_o;
  logic        done_o;
  logic        busy_o;
  logic        fault_o;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  mem_access dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .start_i           (start_i),
    .write_i           (write_i),
    .size_i            (size_i),
    .address_i         (address_i),
    .byte_offset_i     (byte_offset_i),
    .store_data_i      (store_data_i),
    .avm_address_o     (avm_address_o),
    .avm_read_o        (avm_read_o),
    .avm_write_o       (avm_write_o),
    .avm_writedata_o   (avm_writedata_o),
    .avm_byteenable_o  (avm_byteenable_o),
    .avm_waitrequest_i (avm_waitrequest_i),
    .avm_readdata_i    (avm_readdata_i),
    .readdata_o        (readdata_o),
    .done_o            (done_o),
    .busy_o            (busy_o),
    .fault_o           (fault_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: an access covers `width` consecutive lanes starting at `first`;
  // lane k maps to byteenable bit 3-k.
  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    int first, width;
    logic [3:0] be;
    case (sz)
      2'd0:    begin first = int'(off);     width = 1; end
      2'd1:    begin first = int'(off) / 2 * 2; width = 2; end
      default: begin first = 0;             width = 4; end
    endcase
    be = 4'b0000;
    for (int k = 0; k < 4; k++)
      if (k >= first && k < first + width) be[3-k] = 1'b1;
    return be;
  endfunction

  function automatic bit model_misaligned(input logic [1:0] sz, input logic [1:0] off);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (sz == 2'd1) return (int'(off) % 2) != 0;
    if (sz == 2'd2) return off != 2'd0;
`endif
    return 1'b0;
  endfunction

  // One request: start, hold through `waits` waitrequest cycles, complete.
  task automatic do_txn(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [1:0] off, input logic [31:0] d, input int waits,
                        input logic [31:0] rd, input bit restart);
    logic [3:0]  ebe;
    logic [31:0] eaddr;
    ebe   = model_be(sz, off);
    eaddr = a - (a % 4);
    @(negedge clk);
    start_i = 1'b1; write_i = wr; size_i = sz; address_i = a;
    byte_offset_i = off; store_data_i = d;
    @(negedge clk);
    start_i = 1'b0; address_i = $urandom; store_data_i = $urandom;
    write_i = $urandom_range(0, 1); size_i = 2'($urandom_range(0, 3));
    if (model_misaligned(sz, off)) begin
      chk("flt_done", done_o, 1); chk("flt_fault", fault_o, 1);
      chk("flt_rd", avm_read_o, 0); chk("flt_wr", avm_write_o, 0);
      @(negedge clk);
      chk("flt_done_end", done_o, 0); chk("flt_fault_end", fault_o, 0);
      chk("flt_busy_end", busy_o, 0); chk("flt_rdata", readdata_o, exp_rd);
      $display("txn wr=%0d sz=%0d addr=%h off=%0d misaligned -> fault", wr, sz, a, off);
      return;
    end
    for (int i = 0; i <= waits; i++) begin
      chk("req_read", avm_read_o, !wr);
      chk("req_write", avm_write_o, wr);
      chk("req_addr", avm_address_o, eaddr);
      chk("req_be", avm_byteenable_o, ebe);
      chk("req_wdata", avm_writedata_o, d);
      chk("req_done", done_o, 0);
      chk("req_busy", busy_o, 1);
      chk("req_fault", fault_o, 0);
      avm_waitrequest_i = (i < waits);
      avm_readdata_i    = (i < waits) ? $urandom : rd;
      if (restart && i == 0) begin
        start_i = 1'b1; address_i = $urandom; write_i = ~wr;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
    end
    start_i = 1'b0; avm_waitrequest_i = 1'($urandom_range(0, 1)); avm_readdata_i = $urandom;
    if (!wr) exp_rd = rd;
    chk("done_pulse", done_o, 1); chk("done_read", avm_read_o, 0);
    chk("done_write", avm_write_o, 0); chk("done_busy", busy_o, 1);
    chk("done_rdata", readdata_o, exp_rd); chk("done_fault", fault_o, 0);
    @(negedge clk);
    chk("idle_done", done_o, 0); chk("idle_busy", busy_o, 0);
    chk("idle_read", avm_read_o, 0); chk("idle_write", avm_write_o, 0);
    chk("idle_rdata", readdata_o, exp_rd);
    $display("txn wr=%0d sz=%0d addr=%h off=%0d waits=%0d be=%b rdata=%h", wr, sz, a, off, waits, ebe, exp_rd);
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; write_i = 1'b0; size_i = 2'd0;
    address_i = '0; byte_offset_i = 2'd0; store_data_i = '0;
    avm_waitrequest_i = 1'b0; avm_readdata_i = '0; exp_rd = '0;
    #1;
    chk("rst_read", avm_read_o, 0); chk("rst_write", avm_write_o, 0);
    chk("rst_done", done_o, 0); chk("rst_busy", busy_o, 0);
    chk("rst_fault", fault_o, 0); chk("rst_addr", avm_address_o, 0);
    chk("rst_wdata", avm_writedata_o, 0); chk("rst_be", avm_byteenable_o, 0);
    chk("rst_rdata", readdata_o, 0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;

    // Word load, zero wait states.
    do_txn(1'b0, 2'd2, 32'h0000_0100, 2'd0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    // Byte store at offset 2 with three wait states.
    do_txn(1'b1, 2'd0, 32'h0000_0204, 2'd2, 32'h0000_AB00, 3, 32'h0, 1'b0);
    // Second start during ACCESS must be ignored.
    do_txn(1'b0, 2'd1, 32'h0000_0302, 2'd2, 32'h0, 2, 32'h1234_5678, 1'b1);
    // Word load at offset 1: faults only with the alignment check built in.
    do_txn(1'b0, 2'd2, 32'h0000_0400, 2'd1, 32'h0, 0, 32'hCAFE_F00D, 1'b0);

    // Reset in the middle of a stalled load.
    @(negedge clk);
    start_i = 1'b1; write_i = 1'b0; size_i = 2'd2; address_i = 32'h0000_0500;
    byte_offset_i = 2'd0; avm_waitrequest_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("mid_read", avm_read_o, 1);
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("mid_rst_read", avm_read_o, 0); chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_addr", avm_address_o, 0); chk("mid_rst_rdata", readdata_o, 0);
    exp_rd = '0;
    @(negedge clk);
    reset_i = 1'b0; avm_waitrequest_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_nodone", done_o, 0); chk("mid_rst_idle_read", avm_read_o, 0);
    $display("txn reset mid-access, transfer abandoned");
    do_txn(1'b0, 2'd2, 32'h0000_0600, 2'd0, 32'h0, 1, 32'h0BAD_F00D, 1'b0);

    for (int n = 0; n < 40; n++)
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
             2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 3)),
             $urandom, 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
